// File: rtl/symme_pwm_pkg.sv
// ============================================================================
// Module      : symme_pwm_pkg
// Description : Shared defaults and FSM state encoding for symme_pwm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package symme_pwm_pkg;

  localparam int unsigned c_cnt_w_def = 16;
  localparam int unsigned c_dt_w_def  = 8;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DT_START = 3'd1,
    ST_H_ON     = 3'd2,
    ST_DT_HL    = 3'd3,
    ST_L_ON     = 3'd4,
    ST_DT_LH    = 3'd5
  } pwm_state_e;

endpackage

`default_nettype wire

// File: rtl/symme_pwm_dt.sv
// ============================================================================
// Module      : symme_pwm_dt
// Description : Complementary output FSM with dead-time insertion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module symme_pwm_dt
  import symme_pwm_pkg::*;
#(
  parameter int DT_W = c_dt_w_def
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            raw_q,
  input  logic            en,
  input  logic [DT_W-1:0] dt_cfg,
  output logic            pwm_h,
  output logic            pwm_l
);

  pwm_state_e      r_state;
  pwm_state_e      w_state_nxt;
  logic [DT_W-1:0] r_dt_cnt;
  logic [DT_W-1:0] w_dt_cnt_nxt;
  logic [DT_W:0]   w_dt_inc;
  logic            w_dt_done;
  logic            w_dt_zero;

  assign w_dt_inc  = {1'b0, r_dt_cnt} + {{DT_W{1'b0}}, 1'b1};
  assign w_dt_done = (w_dt_inc == {1'b0, dt_cfg});
  assign w_dt_zero = (dt_cfg == '0);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state  <= ST_OFF;
      r_dt_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dt_cnt <= w_dt_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dt_cnt_nxt = r_dt_cnt;
    if (!en) begin
      w_state_nxt  = ST_OFF;
      w_dt_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_dt_cnt_nxt = '0;
          if (w_dt_zero) w_state_nxt = raw_q ? ST_H_ON : ST_L_ON;
          else           w_state_nxt = ST_DT_START;
        end
        ST_DT_START: begin
          if (w_dt_done) begin
            w_state_nxt  = raw_q ? ST_H_ON : ST_L_ON;
            w_dt_cnt_nxt = '0;
          end else begin
            w_dt_cnt_nxt = w_dt_inc[DT_W-1:0];
          end
        end
        ST_H_ON: begin
          if (!raw_q) begin
            w_state_nxt  = w_dt_zero ? ST_L_ON : ST_DT_HL;
            w_dt_cnt_nxt = '0;
          end
        end
        // A level that bounces back during dead time returns to the old side
        ST_DT_HL: begin
          if (raw_q) begin
            w_state_nxt  = ST_H_ON;
            w_dt_cnt_nxt = '0;
          end else if (w_dt_done) begin
            w_state_nxt  = ST_L_ON;
            w_dt_cnt_nxt = '0;
          end else begin
            w_dt_cnt_nxt = w_dt_inc[DT_W-1:0];
          end
        end
        ST_L_ON: begin
          if (raw_q) begin
            w_state_nxt  = w_dt_zero ? ST_H_ON : ST_DT_LH;
            w_dt_cnt_nxt = '0;
          end
        end
        ST_DT_LH: begin
          if (!raw_q) begin
            w_state_nxt  = ST_L_ON;
            w_dt_cnt_nxt = '0;
          end else if (w_dt_done) begin
            w_state_nxt  = ST_H_ON;
            w_dt_cnt_nxt = '0;
          end else begin
            w_dt_cnt_nxt = w_dt_inc[DT_W-1:0];
          end
        end
        default: begin
          w_state_nxt  = ST_OFF;
          w_dt_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign pwm_h = (r_state == ST_H_ON);
  assign pwm_l = (r_state == ST_L_ON);

endmodule

`default_nettype wire

// File: rtl/symme_pwm.sv
// ============================================================================
// Module      : symme_pwm
// Description : Center-aligned complementary PWM with shadowed compare and
//               dead time. Define SYMME_PWM_BRK_EN to add the break input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module symme_pwm
  import symme_pwm_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_def,
  parameter int DT_W  = c_dt_w_def
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic             cmp_wr,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic [DT_W-1:0]  dt_cfg,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             cmp_upd
`ifdef SYMME_PWM_BRK_EN
  ,
  input  logic             brk,
  input  logic             brk_clr,
  output logic             brk_flag
`endif
);

  logic [CNT_W-1:0] r_cnt_prev;
  logic [CNT_W-1:0] r_cmp_shadow;
  logic [CNT_W-1:0] r_cmp_act;
  logic             r_pending;
  logic             r_raw_q;
  logic             r_cmp_upd;
  logic             w_boundary;
  logic             w_load;
  logic             w_run_en;

  assign w_boundary = en && (cnt == '0) && (r_cnt_prev != '0);
  assign w_load     = w_boundary && r_pending;

  // A write coinciding with the boundary stays pending for one more period
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_cnt_prev   <= '0;
      r_cmp_shadow <= '0;
      r_cmp_act    <= '0;
      r_pending    <= 1'b0;
      r_raw_q      <= 1'b0;
      r_cmp_upd    <= 1'b0;
    end else begin
      r_cnt_prev <= cnt;
      r_cmp_upd  <= w_load;
      r_raw_q    <= (cnt < r_cmp_act);
      if (w_load) r_cmp_act <= r_cmp_shadow;
      if (cmp_wr) begin
        r_cmp_shadow <= cmp_val;
        r_pending    <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cmp_upd = r_cmp_upd;

`ifdef SYMME_PWM_BRK_EN
  logic r_brk_flag;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                 r_brk_flag <= 1'b0;
    else if (brk)             r_brk_flag <= 1'b1;
    else if (brk_clr)         r_brk_flag <= 1'b0;
  end

  assign brk_flag = r_brk_flag;
  assign w_run_en = en && !brk && !r_brk_flag;
`else
  assign w_run_en = en;
`endif

  symme_pwm_dt #(
    .DT_W (DT_W)
  ) u_dt (
    .clk    (clk),
    .rstn   (rstn),
    .raw_q  (r_raw_q),
    .en     (w_run_en),
    .dt_cfg (dt_cfg),
    .pwm_h  (pwm_h),
    .pwm_l  (pwm_l)
  );

endmodule

`default_nettype wire

// File: tb/tb_symme_pwm.sv
// ============================================================================
// Module      : tb_symme_pwm
// Description : Self-checking bench for symme_pwm driven by a 0..5..0 triangle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_symme_pwm;
  import symme_pwm_pkg::*;

  localparam int CNT_W = 16;
  localparam int DT_W  = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             en = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  logic             cmp_wr = 1'b0;
  logic [CNT_W-1:0] cmp_val = '0;
  logic [DT_W-1:0]  dt_cfg = '0;
  logic             pwm_h, pwm_l, cmp_upd;
`ifdef SYMME_PWM_BRK_EN
  logic             brk = 1'b0, brk_clr = 1'b0, brk_flag;
`endif

  int n_vec = 0;
  int n_err = 0;
  int phase = 0;

  symme_pwm #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .cnt     (cnt),
    .cmp_wr  (cmp_wr),
    .cmp_val (cmp_val),
    .dt_cfg  (dt_cfg),
    .pwm_h   (pwm_h),
    .pwm_l   (pwm_l),
    .cmp_upd (cmp_upd)
`ifdef SYMME_PWM_BRK_EN
    ,
    .brk      (brk),
    .brk_clr  (brk_clr),
    .brk_flag (brk_flag)
`endif
  );

  always #12.5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] tri_val(input int p);
    return (p <= 5) ? CNT_W'(p) : CNT_W'(10 - p);
  endfunction

  // Reference model: compare reload rules plus a "committed side" view of the
  // dead-time behaviour (a side switch needs dt+1 consecutive cycles of the
  // opposite level; staying on the committed side needs none).
  logic [CNT_W-1:0] m_prev = '0, m_shadow = '0, m_act = '0;
  logic             m_pend = 1'b0, m_raw = 1'b0, m_flag = 1'b0;
  int               m_side = 0, m_en_run = 0, m_run1 = 0, m_run0 = 0;
  logic             e_h = 1'b0, e_l = 1'b0, e_upd = 1'b0;

  always @(posedge clk) begin
    logic bnd, load, d, go;
    if (rstn) begin
      m_prev = '0; m_shadow = '0; m_act = '0; m_pend = 1'b0; m_raw = 1'b0;
      m_flag = 1'b0; m_side = 0; m_en_run = 0; m_run1 = 0; m_run0 = 0;
      e_h = 1'b0; e_l = 1'b0; e_upd = 1'b0;
    end else begin
      bnd  = en && (cnt == 0) && (m_prev != 0);
      load = bnd && m_pend;
      d    = m_raw;
      go   = en;
`ifdef SYMME_PWM_BRK_EN
      go = en && !brk && !m_flag;
      if (brk)          m_flag = 1'b1;
      else if (brk_clr) m_flag = 1'b0;
`endif
      m_raw = (cnt < m_act);
      if (load) m_act = m_shadow;
      if (cmp_wr) begin m_shadow = cmp_val; m_pend = 1'b1; end
      else if (load) m_pend = 1'b0;
      m_prev = cnt;
      e_upd  = load;
      if (d) begin m_run1++; m_run0 = 0; end
      else   begin m_run0++; m_run1 = 0; end
      if (!go) begin
        m_side = 0; m_en_run = 0;
      end else begin
        m_en_run++;
        if (m_side == 0) begin
          if (m_en_run >= int'(dt_cfg) + 1) m_side = d ? 1 : 2;
        end else if (m_side == 1) begin
          if (!d && m_run0 >= int'(dt_cfg) + 1) m_side = 2;
        end else begin
          if (d && m_run1 >= int'(dt_cfg) + 1) m_side = 1;
        end
      end
      e_h = go && (m_side == 1) && d;
      e_l = go && (m_side == 2) && !d;
    end
  end

  always @(negedge clk) begin
    check("cyc_pwm_h", 32'(pwm_h), rstn ? 32'd0 : 32'(e_h));
    check("cyc_pwm_l", 32'(pwm_l), rstn ? 32'd0 : 32'(e_l));
    check("cyc_cmp_upd", 32'(cmp_upd), rstn ? 32'd0 : 32'(e_upd));
    check("cyc_overlap", 32'(pwm_h & pwm_l), 32'd0);
`ifdef SYMME_PWM_BRK_EN
    check("cyc_brk_flag", 32'(brk_flag), rstn ? 32'd0 : 32'(m_flag));
`endif
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cmp_wr = 1'b0;
`ifdef SYMME_PWM_BRK_EN
      brk = 1'b0;
      brk_clr = 1'b0;
`endif
      phase = (phase + 1) % 10;
      cnt = tri_val(phase);
    end
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    while (phase != p && k < 12) begin cyc(1); k++; end
  endtask

  task automatic wait_h(input logic lvl, input string nm);
    int k = 0;
    while (pwm_h !== lvl && k < 40) begin cyc(1); k++; end
    check(nm, 32'(pwm_h), 32'(lvl));
  endtask

  task automatic count10(output int nh, output int nl, output int nz, output int nu);
    nh = 0; nl = 0; nz = 0; nu = 0;
    repeat (10) begin
      cyc(1);
      nh += int'(pwm_h);
      nl += int'(pwm_l);
      nz += int'(!pwm_h && !pwm_l);
      nu += int'(cmp_upd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nh, nl, nz, nu;
    cyc(3);
    check("rst_pwm_h", 32'(pwm_h), 32'd0);
    check("rst_pwm_l", 32'(pwm_l), 32'd0);
    check("rst_cmp_upd", 32'(cmp_upd), 32'd0);
    check("rst_cmp_act", 32'(dut.r_cmp_act), 32'd0);

    // cmp=3, no dead time
    rstn = 1'b0; cmp_val = 3; cmp_wr = 1'b1; cyc(1);
    en = 1'b1; cyc(25);
    wait_phase(3);
    check("xing_h_e0", 32'(pwm_h), 32'd1); cyc(1);
    check("xing_h_e1", 32'(pwm_h), 32'd1); cyc(1);
    check("xing_h_e2", 32'(pwm_h), 32'd0);
    check("xing_l_e2", 32'(pwm_l), 32'd1);
    count10(nh, nl, nz, nu);
    check("dt0_h_cnt", 32'(nh), 32'd5);
    check("dt0_l_cnt", 32'(nl), 32'd5);

    // enable dropped while high side is on
    wait_h(1'b1, "endrop_wait");
    en = 1'b0; cyc(1);
    check("endrop_h", 32'(pwm_h), 32'd0);
    check("endrop_l", 32'(pwm_l), 32'd0);

    // dead time 2
    dt_cfg = 2; en = 1'b1; cyc(20);
    count10(nh, nl, nz, nu);
    check("dt2_h_cnt", 32'(nh), 32'd3);
    check("dt2_l_cnt", 32'(nl), 32'd3);
    check("dt2_gap_cnt", 32'(nz), 32'd4);

    // mid-period shadow write of 4
    en = 1'b0; cyc(1); dt_cfg = 0; en = 1'b1; cyc(12);
    wait_phase(3);
    cmp_val = 4; cmp_wr = 1'b1;
    count10(nh, nl, nz, nu);
    check("wr4_upd_cnt", 32'(nu), 32'd1);
    cyc(10);
    count10(nh, nl, nz, nu);
    check("cmp4_h_cnt", 32'(nh), 32'd7);
    check("cmp4_l_cnt", 32'(nl), 32'd3);

    // write coincident with the boundary
    wait_phase(5);
    cmp_val = 5; cmp_wr = 1'b1; cyc(1);
    wait_phase(0);
    cmp_val = 2; cmp_wr = 1'b1; cyc(1);
    check("co_act_old", 32'(dut.r_cmp_act), 32'd5);
    check("co_upd1", 32'(cmp_upd), 32'd1);
    cyc(9);
    check("co_act_hold", 32'(dut.r_cmp_act), 32'd5);
    cyc(1);
    check("co_act_new", 32'(dut.r_cmp_act), 32'd2);
    check("co_upd2", 32'(cmp_upd), 32'd1);

    // compare extremes with dead time enabled
    en = 1'b0; cyc(1); dt_cfg = 2; en = 1'b1;
    cmp_val = 6; cmp_wr = 1'b1; cyc(25);
    count10(nh, nl, nz, nu);
    check("c6_h_cnt", 32'(nh), 32'd10);
    check("c6_gap_cnt", 32'(nz), 32'd0);
    cmp_val = 0; cmp_wr = 1'b1; cyc(25);
    count10(nh, nl, nz, nu);
    check("c0_l_cnt", 32'(nl), 32'd10);
    check("c0_gap_cnt", 32'(nz), 32'd0);

    // asynchronous reset while high side is on
    cmp_val = 3; cmp_wr = 1'b1; cyc(25);
    wait_h(1'b1, "ar_wait_h");
    #2 rstn = 1'b1;
    #1 check("ar_h", 32'(pwm_h), 32'd0);
    check("ar_l", 32'(pwm_l), 32'd0);
    cyc(2);
    rstn = 1'b0; cmp_val = 3; cmp_wr = 1'b1; cyc(30);

    // asynchronous reset inside the high-to-low dead time
    wait_h(1'b1, "ardt_wait_h");
    wait_h(1'b0, "ardt_wait_fall");
    check("ardt_in_gap", 32'(pwm_l), 32'd0);
    #2 rstn = 1'b1;
    #1 check("ardt_h", 32'(pwm_h), 32'd0);
    check("ardt_l", 32'(pwm_l), 32'd0);
    check("ardt_act", 32'(dut.r_cmp_act), 32'd0);
    check("ardt_state", 32'(dut.u_dt.r_state), 32'(ST_OFF));
    cyc(2);
    rstn = 1'b0; cmp_val = 3; cmp_wr = 1'b1; cyc(30);

`ifdef SYMME_PWM_BRK_EN
    wait_h(1'b1, "brk_wait_h");
    brk = 1'b1; cyc(1);
    check("brk_h", 32'(pwm_h), 32'd0);
    check("brk_l", 32'(pwm_l), 32'd0);
    check("brk_flag_set", 32'(brk_flag), 32'd1);
    cyc(5);
    check("brk_flag_hold", 32'(brk_flag), 32'd1);
    check("brk_hold_out", 32'(pwm_h | pwm_l), 32'd0);
    brk_clr = 1'b1; cyc(1);
    check("brk_flag_clr", 32'(brk_flag), 32'd0);
    cyc(1);
    check("brk_dt_start", 32'(dut.u_dt.r_state), 32'(ST_DT_START));
    cyc(20);
`endif

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/symme_pwm.md
SYMME_PWM -- requirements
Module: symme_pwm

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of timebase count and compare values.
REQ-002 SHALL have parameter DT_W, default 8, width of dead-time configuration.
REQ-003 SHALL have ports: clk  input  1  clock, rising-edge active.
REQ-004 SHALL have ports: rstn  input  1  reset rstn, asynchronous, active-high.
REQ-005 SHALL have ports: en  input  1  output enable.
REQ-006 SHALL have ports: cnt  input  CNT_W  symmetric triangle count from the timebase (0..max..0).
REQ-007 SHALL have ports: cmp_wr  input  1  one-cycle write strobe for the shadow compare register.
REQ-008 SHALL have ports: cmp_val  input  CNT_W  compare value sampled on cmp_wr.
REQ-009 SHALL have ports: dt_cfg  input  DT_W  dead-time in clk cycles, static while en=1.
REQ-010 SHALL have ports: pwm_h  output  1  high-side drive, and pwm_l  output  1  low-side drive.
REQ-011 SHALL have ports: cmp_upd  output  1  one-cycle pulse when the active compare reloads.

Function
REQ-012 SHALL latch cmp_val into cmp_shadow on cmp_wr and set a pending flag.
REQ-013 SHALL define a period boundary as en=1, cnt==0, and previous-cycle cnt!=0.
REQ-014 SHALL, at a boundary with pending=1, copy cmp_shadow to cmp_act, clear pending, and pulse cmp_upd for the next cycle only.
REQ-015 SHALL, when cmp_wr and the boundary coincide, load the old shadow into cmp_act; the new value stays pending until the next boundary.
REQ-016 SHALL register raw_q <= (cnt < cmp_act), unsigned: cmp_act=0 gives constant 0; cmp_act>peak gives constant 1.
REQ-017 SHALL run an FSM with states OFF, DT_START, H_ON, DT_HL, L_ON, DT_LH; pwm_h=1 only in H_ON, pwm_l=1 only in L_ON.
REQ-018 SHALL go from OFF to DT_START on en=1; DT_START holds dt_cfg cycles, then enters H_ON if raw_q=1, else L_ON.
REQ-019 SHALL, in L_ON with raw_q=1, enter DT_LH for dt_cfg cycles, then H_ON; symmetric H_ON/raw_q=0 -> DT_HL -> L_ON.
REQ-020 SHALL skip dead-time states when dt_cfg=0, switching ON state directly; pwm edges lag the cnt crossing by exactly 2 cycles plus dt_cfg.
REQ-021 SHALL, if raw_q returns to the prior level during DT_LH/DT_HL, go back to the prior ON state with no output glitch.
REQ-022 SHALL, on en=0, enter OFF at the next edge (both outputs 0), clear the dead-time counter, and keep cmp_shadow, cmp_act, and pending.
REQ-023 SHALL never drive pwm_h and pwm_l high in the same cycle.

Reset
REQ-024 SHALL, while rstn=1, force state=OFF, pwm_h=0, pwm_l=0, cmp_upd=0, cmp_shadow=0, cmp_act=0, pending=0, raw_q=0, and dead-time counter=0.
REQ-025 SHALL, when reset is asserted mid-operation (including during a DT state), clear both outputs immediately and asynchronously.

Configuration
REQ-026 SHALL, with SYMME_PWM_BRK_EN defined, add brk input 1, brk_clr input 1, and brk_flag output 1.
REQ-027 SHALL, with SYMME_PWM_BRK_EN defined, on brk=1 set brk_flag and enter OFF at the next edge.
REQ-028 SHALL, with SYMME_PWM_BRK_EN defined, hold OFF while brk_flag=1; brk_clr with brk=0 clears brk_flag, then REQ-018 resumes.
REQ-029 SHALL, without SYMME_PWM_BRK_EN, omit these ports and logic and behave as brk=0.

Structure
REQ-030 SHALL place the FSM state enum and CNT_W/DT_W defaults in package symme_pwm_pkg.
REQ-031 SHALL implement the dead-time counter and FSM in sub-module symme_pwm_dt (inputs raw_q, en, dt_cfg; outputs pwm_h, pwm_l).

Verification (40 MHz clk, symme_timer source, cfg_max=5, period 10 cycles)
REQ-032 SHALL check: cmp=3, dt_cfg=0 -> pwm_h high 5 of 10 cycles, pwm_l high the other 5, edges 2 cycles after the cnt crossing.
REQ-033 SHALL check: cmp=3, dt_cfg=2 -> pwm_h 3 cycles, pwm_l 3 cycles, two 2-cycle both-low gaps per period.
REQ-034 SHALL check: cmp_wr of 4 mid-period -> no duty change until the next cnt==0, one cmp_upd pulse, then pwm_h 7 of 10; a write coincident with the boundary applies one period later.
REQ-035 SHALL check: cmp=0 -> pwm_l constant after startup; cmp=6 -> pwm_h constant, with no dead-time gaps in either case.
REQ-036 SHALL check: en dropped during H_ON -> both outputs 0 the next cycle; rstn pulsed mid-DT -> outputs 0 immediately and cmp_act=0.
REQ-037 SHALL check, with SYMME_PWM_BRK_EN: brk pulse -> outputs 0 next cycle and brk_flag=1 until brk_clr, then DT_START is re-entered.
